dsp_feeder: RTL and testbench

DSP_FEEDER -- requirements
Module: dsp_feeder

---
 rtl/dsp_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/dsp_feeder.sv | 143 ++++++++++++++
 tb/tb_dsp_feeder.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared definitions for the dsp feeder and the dsp stage it writes into.
// Holds the sequencer state encoding and the widths of the control fields.
package dsp_pkg;

  localparam int unsigned PARAM_W = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStart  = 2'd1,
    StStream = 2'd2,
    StDone   = 2'd3
  } state_e;

  // True when one more write brings the sample counter up to the block length.
  function automatic logic reaches_len(input logic [CNT_W-1:0] cnt, input int unsigned len);
    return (32'(cnt) + 32'd1) == len;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered single-clock FIFO; a word pushed on one edge is visible at the head
// only from the following cycle. Depth must be a power of two.
module sync_fifo #(
  parameter int unsigned  Width = 24,
  parameter int unsigned  Depth = 8,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == CntW'(Depth));
    empty    = (count_q == '0);
    // A full FIFO refuses a push even when a pop frees a slot on the same edge.
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dsp_feeder.sv
// Buffers upstream samples and streams one block of block_len writes into the dsp
// stage per accepted go, framed by a start pulse and a trailing done pulse.
module dsp_feeder
  import dsp_pkg::*;
#(
  parameter int unsigned bus_width  = 24,
  parameter int unsigned fifo_depth = 8,
  parameter int unsigned block_len  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_valid,
  input  logic [bus_width-1:0] s_data,
  output logic                 s_ready,
  input  logic                 go,
  input  logic [PARAM_W-1:0]   cfg_param,
  input  logic                 en,
  output logic                 start,
  output logic [PARAM_W-1:0]   param,
  output logic [ADDR_W-1:0]    addr,
  output logic [bus_width-1:0] din,
  output logic                 we,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned FifoCntW = $clog2(fifo_depth) + 1;

  state_e               state_q, state_d;
  logic [PARAM_W-1:0]   param_q, param_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [bus_width-1:0] din_q, din_d;
  logic                 we_q, we_d;
  logic                 done_q, done_d;

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [bus_width-1:0] fifo_rdata;
  logic [FifoCntW-1:0]  fifo_count;
  logic                 unused_fifo_count;
  logic                 go_accept, pop_fire, last_pop;

  sync_fifo #(
    .Width (bus_width),
    .Depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (s_valid),
    .wdata (s_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;

  assign go_accept = (state_q == StIdle) && go;
  assign pop_fire  = fifo_pop && !fifo_empty;
  assign last_pop  = pop_fire && reaches_len(cnt_q, block_len);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (go_accept) state_d = StStart;
      StStart:  state_d = StStream;
      StStream: if (last_pop) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    start    = 1'b0;
    busy     = 1'b1;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle:   busy = 1'b0;
      StStart:  start = 1'b1;
      StStream: fifo_pop = en;
      StDone:   ;
      default:  busy = 1'b0;
    endcase
  end

  // Write-port datapath; addr and din hold across stalls so the dsp stage sees stable values.
  always_comb begin
    param_d = param_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = pop_fire;
    done_d  = (state_q == StDone);
    if (go_accept) begin
      param_d = cfg_param;
      cnt_d   = '0;
    end
    if (pop_fire) begin
      din_d  = fifo_rdata;
      addr_d = cnt_q[ADDR_W-1:0];
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      param_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      param_q <= param_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign s_ready = !fifo_full;
  assign param   = param_q;
  assign addr    = addr_q;
  assign din     = din_q;
  assign we      = we_q;
  assign done    = done_q;

endmodule

// File: tb/tb_dsp_feeder.sv
// Directed bench for dsp_feeder: instance u_dut uses block_len=4/depth 8, instance
// u_dut_b uses block_len=10/depth 16 for the address-wrap scenario.
module tb_dsp_feeder;

  logic        clk;
  logic        rstn;
  logic        s_valid;
  logic [23:0] s_data;
  logic        go;
  logic [7:0]  cfg_param;
  logic        en;

  logic        s_ready, start, we, busy, done;
  logic [7:0]  param;
  logic [2:0]  addr;
  logic [23:0] din;

  logic        s_ready_b, start_b, we_b, busy_b, done_b;
  logic [7:0]  param_b;
  logic [2:0]  addr_b;
  logic [23:0] din_b;

  int n_cmp;
  int n_err;

  dsp_feeder #(
    .bus_width  (24),
    .fifo_depth (8),
    .block_len  (4)
  ) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .go        (go),
    .cfg_param (cfg_param),
    .en        (en),
    .start     (start),
    .param     (param),
    .addr      (addr),
    .din       (din),
    .we        (we),
    .busy      (busy),
    .done      (done)
  );

  dsp_feeder #(
    .bus_width  (24),
    .fifo_depth (16),
    .block_len  (10)
  ) u_dut_b (
    .clk       (clk),
    .rstn      (rstn),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready_b),
    .go        (go),
    .cfg_param (cfg_param),
    .en        (en),
    .start     (start_b),
    .param     (param_b),
    .addr      (addr_b),
    .din       (din_b),
    .we        (we_b),
    .busy      (busy_b),
    .done      (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [23:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulse_go(input logic [7:0] p);
    go        = 1'b1;
    cfg_param = p;
    tick();
    go = 1'b0;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    go        = 1'b0;
    cfg_param = '0;
    en        = 1'b1;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    s_valid = 1'b0; s_data = '0; go = 1'b0; cfg_param = '0; en = 1'b1;
    #2;
    n_cmp++;
    if ({start, we, done, busy} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got start/we/done/busy=%b, want 0000", {start, we, done, busy});
    end
    n_cmp++;
    if ({param, addr, din} !== 35'h0) begin
      n_err++;
      $display("FAIL reset_data: got param=%h addr=%0d din=%h, want all 0", param, addr, din);
    end
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got s_ready=%b, want 1", s_ready);
    end
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_basic_block();
    do_reset();
    for (int i = 0; i < 4; i++) push_one(24'(24'h11 + i));
    pulse_go(8'h5A);
    n_cmp++;
    if ({start, busy, param} !== {1'b1, 1'b1, 8'h5A}) begin
      n_err++;
      $display("FAIL basic_start: got start=%b busy=%b param=%h, want 1 1 5a", start, busy, param);
    end
    tick();
    n_cmp++;
    if (start !== 1'b0) begin
      n_err++;
      $display("FAIL basic_start_width: got start=%b, want 0", start);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({we, addr, din} !== {1'b1, 3'(i), 24'(24'h11 + i)}) begin
        n_err++;
        $display("FAIL basic_write[%0d]: got we=%b addr=%0d din=%h, want 1 %0d %h",
                 i, we, addr, din, i, 24'(24'h11 + i));
      end
    end
    tick();
    n_cmp++;
    if ({we, done, busy} !== 3'b010) begin
      n_err++;
      $display("FAIL basic_done: got we/done/busy=%b, want 010", {we, done, busy});
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_width: got done=%b, want 0", done);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (s_ready !== 1'b1) begin
        n_err++;
        $display("FAIL full_ready_before[%0d]: got s_ready=%b, want 1", i, s_ready);
      end
      push_one(24'(24'h21 + i));
    end
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready_after8: got s_ready=%b, want 0", s_ready);
    end
    s_valid = 1'b1;
    s_data  = 24'h000099;
    tick();
    pulse_go(8'h01);
    tick();
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready_held: got s_ready=%b, want 0", s_ready);
    end
    tick();
    n_cmp++;
    if ({we, din, s_ready} !== {1'b1, 24'h000021, 1'b1}) begin
      n_err++;
      $display("FAIL full_first_pop: got we=%b din=%h s_ready=%b, want 1 000021 1", we, din, s_ready);
    end
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if ({we, din, s_ready} !== {1'b1, 24'h000022, 1'b1}) begin
      n_err++;
      $display("FAIL full_push_pop: got we=%b din=%h s_ready=%b, want 1 000022 1", we, din, s_ready);
    end
    repeat (3) tick();
    pulse_go(8'h02);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({we, addr, din} !== {1'b1, 3'(i), 24'(24'h25 + i)}) begin
        n_err++;
        $display("FAIL full_block2[%0d]: got we=%b addr=%0d din=%h, want 1 %0d %h",
                 i, we, addr, din, i, 24'(24'h25 + i));
      end
    end
    tick();
    pulse_go(8'h03);
    tick();
    tick();
    n_cmp++;
    if ({we, addr, din} !== {1'b1, 3'd0, 24'h000099}) begin
      n_err++;
      $display("FAIL full_ninth: got we=%b addr=%0d din=%h, want 1 0 000099", we, addr, din);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({we, busy} !== 2'b01) begin
        n_err++;
        $display("FAIL full_no_dup[%0d]: got we=%b busy=%b, want 0 1", i, we, busy);
      end
    end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    for (int i = 0; i < 10; i++) push_one(24'(24'h31 + i));
    pulse_go(8'h10);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({we_b, addr_b, din_b} !== {1'b1, 3'(i % 8), 24'(24'h31 + i)}) begin
        n_err++;
        $display("FAIL wrap_write[%0d]: got we=%b addr=%0d din=%h, want 1 %0d %h",
                 i, we_b, addr_b, din_b, i % 8, 24'(24'h31 + i));
      end
    end
    tick();
    n_cmp++;
    if ({we_b, done_b, busy_b} !== 3'b010) begin
      n_err++;
      $display("FAIL wrap_done: got we/done/busy=%b, want 010", {we_b, done_b, busy_b});
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 4; i++) push_one(24'(24'h41 + i));
    pulse_go(8'h20);
    tick();
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({we, addr, din} !== {1'b0, 3'd1, 24'h000042}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got we=%b addr=%0d din=%h, want 0 1 000042",
                 i, we, addr, din);
      end
    end
    en = 1'b1;
    for (int i = 2; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({we, addr, din} !== {1'b1, 3'(i), 24'(24'h41 + i)}) begin
        n_err++;
        $display("FAIL stall_resume[%0d]: got we=%b addr=%0d din=%h, want 1 %0d %h",
                 i, we, addr, din, i, 24'(24'h41 + i));
      end
    end
    tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL stall_done: got done=%b, want 1", done);
    end
  endtask

  task automatic test_reset_mid_block();
    do_reset();
    for (int i = 0; i < 4; i++) push_one(24'(24'h51 + i));
    pulse_go(8'h3C);
    tick();
    tick();
    tick();
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({start, we, done, busy, s_ready} !== 5'b00001) begin
      n_err++;
      $display("FAIL midrst_flags: got start/we/done/busy/s_ready=%b, want 00001",
               {start, we, done, busy, s_ready});
    end
    n_cmp++;
    if ({param, addr, din} !== 35'h0) begin
      n_err++;
      $display("FAIL midrst_data: got param=%h addr=%0d din=%h, want all 0", param, addr, din);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_no_done: got done=%b, want 0", done);
    end
    rstn = 1'b1;
    pulse_go(8'h11);
    tick();
    n_cmp++;
    if (param !== 8'h11) begin
      n_err++;
      $display("FAIL midrst_param: got param=%h, want 11", param);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (we !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_empty[%0d]: got we=%b, want 0", i, we);
      end
    end
    push_one(24'h000061);
    n_cmp++;
    if (we !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_no_fallthrough: got we=%b, want 0", we);
    end
    tick();
    n_cmp++;
    if ({we, addr, din} !== {1'b1, 3'd0, 24'h000061}) begin
      n_err++;
      $display("FAIL midrst_first: got we=%b addr=%0d din=%h, want 1 0 000061", we, addr, din);
    end
  endtask

  task automatic test_go_while_busy();
    do_reset();
    for (int i = 0; i < 4; i++) push_one(24'(24'h71 + i));
    pulse_go(8'h5A);
    tick();
    tick();
    go        = 1'b1;
    cfg_param = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({start, param} !== {1'b0, 8'h5A}) begin
        n_err++;
        $display("FAIL busygo_stream[%0d]: got start=%b param=%h, want 0 5a", i, start, param);
      end
    end
    tick();
    go = 1'b0;
    n_cmp++;
    if ({done, start, param} !== {1'b1, 1'b0, 8'h5A}) begin
      n_err++;
      $display("FAIL busygo_done: got done=%b start=%b param=%h, want 1 0 5a", done, start, param);
    end
    tick();
    n_cmp++;
    if ({busy, start} !== 2'b00) begin
      n_err++;
      $display("FAIL busygo_idle: got busy=%b start=%b, want 0 0", busy, start);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic_block();
    test_fifo_full();
    test_addr_wrap();
    test_stall();
    test_reset_mid_block();
    test_go_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
